mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised data-memory stage for the 5-stage core, replacing the single-cycle MEM stage. It sits between EX and WB. It issues loads and stores to data memory over a req/ack handshake and stalls upstream while memory is busy. It generates store byte-enables, aligns and sign-extends load data (big-endian), forwards WB results into store data, and holds the MEM/WB pipeline register.

## Interface
- ADDR_W, 32, data-memory address width (low 2 bits are the byte offset)
- DM_TIMEOUT, 255, maximum cycles waiting for dm_ack before abort (≥1, ≤1023)
- CLK in 1: clock, rising edge
- RESET in 1: asynchronous, active-low reset
- in_valid in 1: EX/MEM holds a valid instruction
- in_ready out 1: stage can accept; low = upstream stall
- ALU_control in 6: operation code (encodings below)
- aluResult in 32: ALU result / effective address
- readDataB in 32: rt value (store data, LWL/LWR merge base)
- writeRegister in 5; do_writeback in 1; MemtoReg in 1; MemRead in 1; MemWrite in 1
- writeData_WB in 32; writeRegister_WB in 5; do_writeback_WB in 1: WB bypass source
- dm_req out 1; dm_we out 1; dm_addr out ADDR_W; dm_wdata out 32; dm_be out 4 (bit3 = byte at offset 0)
- dm_ack in 1; dm_rdata in 32
- out_valid out 1; aluResult_PR out 32; data_read_PR out 32; writeRegister_PR out 5; MemtoReg_PR out 1; do_writeback_PR out 1
- dm_err_PR out 1: access aborted by timeout
- misalign_PR out 1: present only with MISALIGN_TRAP_EN

## Operation
- Opcodes: LB 100001, LBU 101010, LH 101011, LHU 101100, LWL 101101, LWR 101110, SB 101000, SH 101001. Any other code with MemRead is LW; any other code with MemWrite is SW.
- Big-endian: offset 0 = bits [31:24].
- Bypass: when do_writeback_WB, writeRegister_WB==writeRegister, and writeRegister≠0, the store/merge base is writeData_WB. Otherwise it is readDataB. The base is sampled at accept.
- Store data is replicated into its lane:
  - SB: byte on all four lanes, dm_be one-hot per offset.
  - SH: halfword on both halves, dm_be 1100 (off 0) or 0011 (off 2).
  - SW: dm_be 1111.
- Load alignment:
  - LB/LBU: selected byte, sign- or zero-extended.
  - LH/LHU: selected halfword (off 0 → [31:16], off 2 → [15:0]), sign- or zero-extended.
  - LW: raw word.
  - LWL at offset k: data_read = {dm_rdata[31-8k:0], base[8k-1:0]}.
  - LWR at offset k: data_read = {base[31:8(k+1)], dm_rdata[31:24-8k]}.
- FSM:
  - IDLE: in_ready=1. On in_valid & !(MemRead|MemWrite), PR loads next edge with out_valid=1.
  - IDLE, on in_valid & (MemRead|MemWrite): latch operands → ACCESS.
  - ACCESS: in_ready=0, dm_req=1, dm_addr/dm_we/dm_wdata/dm_be driven from the latch and held stable. Wait counter increments each cycle.
  - ACCESS, dm_ack=1: PR loads the aligned load (or the store, with do_writeback from the latch), out_valid=1 → IDLE.
  - ACCESS, counter==DM_TIMEOUT without ack: PR loads with dm_err_PR=1, do_writeback_PR=0, out_valid=1 → IDLE.
- When no accept and no completion, out_valid=0 next cycle. The PR data holds its value.
- dm_ack outside ACCESS is ignored.

## Timing
- Reset (RESET low, asynchronous): state IDLE, counter 0. in_ready=1 after reset; all other outputs 0 (dm_req, dm_we, dm_be, dm_addr, dm_wdata, every *_PR, out_valid, dm_err_PR).
- Reset mid-ACCESS drops dm_req immediately and discards the access.
- Non-memory latency: 1 cycle.
- Memory latency: accept at edge N; dm_req high from N+1; ack sampled at edge M; PR valid after M. Zero-wait memory (ack in first ACCESS cycle) gives 2 cycles.
- Back-to-back: in_ready rises in the cycle after the ack. A new accept can coincide with out_valid of the previous access.
- The ack and the timeout edge can coincide; ack wins (dm_err_PR=0).

## Configuration
- MISALIGN_TRAP_EN defined:
  - LH/LHU/SH at an odd offset, or LW/SW at a nonzero offset, skips ACCESS. No dm_req is issued.
  - PR loads next cycle with misalign_PR=1 and do_writeback_PR=0.
- Undefined: misalign_PR port is absent. Misaligned halfword/word accesses are issued, with the address truncated to alignment (low bits ignored for lane selection).

## Test plan
- Non-memory: ALU add, aluResult=0x1234, writeRegister=5 → next cycle out_valid=1, aluResult_PR=0x1234, writeRegister_PR=5, dm_req never high.
- LB, address 0x101, dm_rdata=0x11F2_3344, ack after 3 wait cycles → in_ready low for 4 cycles, data_read_PR=0xFFFF_FFF2. Same access with LBU → 0x0000_00F2.
- SB, address 0x102, rt=$7, readDataB=0xAA, WB writing $7=0x5C → dm_we=1, dm_be=0010, dm_wdata=0x5C5C_5C5C. The same case with writeRegister=0 does not bypass.
- LWL, offset 1, base=0xAABB_CCDD, dm_rdata=0x1122_3344 → data_read_PR=0x2233_44DD. LWR, offset 1 → 0xAABB_1122.
- Memory never acks with DM_TIMEOUT=4 → dm_req high exactly 5 cycles, then dm_err_PR=1, do_writeback_PR=0. Reset asserted in the 2nd ACCESS cycle → dm_req drops asynchronously, in_ready=1.
- With MISALIGN_TRAP_EN: LW at 0x102 → no dm_req, misalign_PR=1 next cycle. Without the macro: dm_req issued, dm_be=1111.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory pipeline stage: req/ack access, byte lanes, big-endian load align, MEM/WB register.
// Optional MISALIGN_TRAP_EN: traps misaligned half/word accesses instead of issuing them.
module mem_access_unit #(
   parameter int ADDR_W     = 32,
   parameter int DM_TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        ALU_control,
   input  logic [31:0]       aluResult,
   input  logic [31:0]       readDataB,
   input  logic [4:0]        writeRegister,
   input  logic              do_writeback,
   input  logic              MemtoReg,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [31:0]       writeData_WB,
   input  logic [4:0]        writeRegister_WB,
   input  logic              do_writeback_WB,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_wdata,
   output logic [3:0]        dm_be,
   input  logic              dm_ack,
   input  logic [31:0]       dm_rdata,
   output logic              out_valid,
   output logic [31:0]       aluResult_PR,
   output logic [31:0]       data_read_PR,
   output logic [4:0]        writeRegister_PR,
   output logic              MemtoReg_PR,
   output logic              do_writeback_PR,
   output logic              dm_err_PR
`ifdef MISALIGN_TRAP_EN
   ,
   output logic              misalign_PR
`endif
);

   localparam logic [5:0] OP_LB  = 6'b100001;
   localparam logic [5:0] OP_LBU = 6'b101010;
   localparam logic [5:0] OP_LH  = 6'b101011;
   localparam logic [5:0] OP_LHU = 6'b101100;
   localparam logic [5:0] OP_LWL = 6'b101101;
   localparam logic [5:0] OP_LWR = 6'b101110;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;

   typedef enum logic [3:0] {
      K_LW, K_LB, K_LBU, K_LH, K_LHU, K_LWL, K_LWR, K_SW, K_SB, K_SH
   } kind_t;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t            state;
   kind_t             kind, l_kind;
   logic [9:0]        cnt;
   logic [1:0]        off, l_off;
   logic [31:0]       base, l_base, l_alu;
   logic [4:0]        l_wreg;
   logic              l_dwb, l_m2r, l_load;
   logic              is_mem;
   logic [31:0]       wdata_n;
   logic [3:0]        be_n;
   logic [ADDR_W-1:0] addr_n;
   logic [31:0]       ld;
   logic [4:0]        sh_b, k8;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;

   assign off    = aluResult[1:0];
   assign is_mem = MemRead | MemWrite;
   assign base   = (do_writeback_WB && writeRegister_WB == writeRegister
                    && writeRegister != 5'd0) ? writeData_WB : readDataB;

   always_comb begin
      kind = K_LW;
      if (MemWrite) begin
         unique case (ALU_control)
            OP_SB:   kind = K_SB;
            OP_SH:   kind = K_SH;
            default: kind = K_SW;
         endcase
      end else begin
         unique case (ALU_control)
            OP_LB:   kind = K_LB;
            OP_LBU:  kind = K_LBU;
            OP_LH:   kind = K_LH;
            OP_LHU:  kind = K_LHU;
            OP_LWL:  kind = K_LWL;
            OP_LWR:  kind = K_LWR;
            default: kind = K_LW;
         endcase
      end
   end

   // Lane enables and replicated store data; misaligned half/word addresses are truncated
   always_comb begin
      wdata_n = base;
      be_n    = 4'b1111;
      addr_n  = aluResult[ADDR_W-1:0];
      unique case (kind)
         K_SB, K_LB, K_LBU: begin
            be_n    = 4'b1000 >> off;
            wdata_n = {4{base[7:0]}};
         end
         K_SH, K_LH, K_LHU: begin
            be_n      = off[1] ? 4'b0011 : 4'b1100;
            wdata_n   = {2{base[15:0]}};
            addr_n[0] = 1'b0;
         end
         K_LWL:   be_n = 4'b1111 >> off;
         K_LWR:   be_n = 4'b1111 << (2'd3 - off);
         default: addr_n[1:0] = 2'b00;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic misalign;
   always_comb begin
      unique case (kind)
         K_LH, K_LHU, K_SH: misalign = off[0];
         K_LW, K_SW:        misalign = |off;
         default:           misalign = 1'b0;
      endcase
   end
`endif

   assign sh_b   = {2'd3 - l_off, 3'b000};
   assign k8     = {l_off, 3'b000};
   assign byte_v = dm_rdata[sh_b +: 8];
   assign half_v = l_off[1] ? dm_rdata[15:0] : dm_rdata[31:16];

   always_comb begin
      unique case (l_kind)
         K_LB:    ld = {{24{byte_v[7]}}, byte_v};
         K_LBU:   ld = {24'd0, byte_v};
         K_LH:    ld = {{16{half_v[15]}}, half_v};
         K_LHU:   ld = {16'd0, half_v};
         K_LWL:   ld = (dm_rdata << k8)
                       | (l_base & ~(32'hFFFF_FFFF << k8));
         K_LWR:   ld = (dm_rdata >> sh_b)
                       | (l_base & ~(32'hFFFF_FFFF >> sh_b));
         default: ld = dm_rdata;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state            <= IDLE;
         cnt              <= '0;
         in_ready         <= 1'b1;
         dm_req           <= 1'b0;
         dm_we            <= 1'b0;
         dm_addr          <= '0;
         dm_wdata         <= '0;
         dm_be            <= '0;
         out_valid        <= 1'b0;
         aluResult_PR     <= '0;
         data_read_PR     <= '0;
         writeRegister_PR <= '0;
         MemtoReg_PR      <= 1'b0;
         do_writeback_PR  <= 1'b0;
         dm_err_PR        <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         misalign_PR      <= 1'b0;
`endif
         l_kind           <= K_LW;
         l_off            <= '0;
         l_base           <= '0;
         l_alu            <= '0;
         l_wreg           <= '0;
         l_dwb            <= 1'b0;
         l_m2r            <= 1'b0;
         l_load           <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  if (!is_mem) begin
                     out_valid        <= 1'b1;
                     aluResult_PR     <= aluResult;
                     writeRegister_PR <= writeRegister;
                     MemtoReg_PR      <= MemtoReg;
                     do_writeback_PR  <= do_writeback;
                     dm_err_PR        <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                     misalign_PR      <= 1'b0;
                  end else if (misalign) begin
                     out_valid        <= 1'b1;
                     aluResult_PR     <= aluResult;
                     writeRegister_PR <= writeRegister;
                     MemtoReg_PR      <= MemtoReg;
                     do_writeback_PR  <= 1'b0;
                     dm_err_PR        <= 1'b0;
                     misalign_PR      <= 1'b1;
`endif
                  end else begin
                     state    <= ACCESS;
                     in_ready <= 1'b0;
                     cnt      <= '0;
                     dm_req   <= 1'b1;
                     dm_we    <= MemWrite;
                     dm_addr  <= addr_n;
                     dm_wdata <= wdata_n;
                     dm_be    <= be_n;
                     l_kind   <= kind;
                     l_off    <= off;
                     l_base   <= base;
                     l_alu    <= aluResult;
                     l_wreg   <= writeRegister;
                     l_dwb    <= do_writeback;
                     l_m2r    <= MemtoReg;
                     l_load   <= MemRead & ~MemWrite;
                  end
               end
            end
            ACCESS: begin
               if (dm_ack || cnt == 10'(DM_TIMEOUT)) begin
                  state            <= IDLE;
                  in_ready         <= 1'b1;
                  dm_req           <= 1'b0;
                  dm_we            <= 1'b0;
                  out_valid        <= 1'b1;
                  aluResult_PR     <= l_alu;
                  writeRegister_PR <= l_wreg;
                  MemtoReg_PR      <= l_m2r;
                  do_writeback_PR  <= dm_ack ? l_dwb : 1'b0;
                  dm_err_PR        <= ~dm_ack;
`ifdef MISALIGN_TRAP_EN
                  misalign_PR      <= 1'b0;
`endif
                  if (dm_ack && l_load) data_read_PR <= ld;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (DM_TIMEOUT=4); honours MISALIGN_TRAP_EN.
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  ALU_control = '0;
   logic [31:0] aluResult = '0;
   logic [31:0] readDataB = '0;
   logic [4:0]  writeRegister = '0;
   logic        do_writeback = 1'b0;
   logic        MemtoReg = 1'b0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] writeData_WB = '0;
   logic [4:0]  writeRegister_WB = '0;
   logic        do_writeback_WB = 1'b0;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [3:0]  dm_be;
   logic        dm_ack = 1'b0;
   logic [31:0] dm_rdata = '0;
   logic        out_valid;
   logic [31:0] aluResult_PR, data_read_PR;
   logic [4:0]  writeRegister_PR;
   logic        MemtoReg_PR, do_writeback_PR, dm_err_PR;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_PR;
`endif

   mem_access_unit #(.ADDR_W(32), .DM_TIMEOUT(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .in_valid(in_valid), .in_ready(in_ready),
      .ALU_control(ALU_control), .aluResult(aluResult),
      .readDataB(readDataB), .writeRegister(writeRegister),
      .do_writeback(do_writeback), .MemtoReg(MemtoReg),
      .MemRead(MemRead), .MemWrite(MemWrite),
      .writeData_WB(writeData_WB),
      .writeRegister_WB(writeRegister_WB),
      .do_writeback_WB(do_writeback_WB),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_be(dm_be),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .out_valid(out_valid), .aluResult_PR(aluResult_PR),
      .data_read_PR(data_read_PR),
      .writeRegister_PR(writeRegister_PR),
      .MemtoReg_PR(MemtoReg_PR),
      .do_writeback_PR(do_writeback_PR),
      .dm_err_PR(dm_err_PR)
`ifdef MISALIGN_TRAP_EN
      , .misalign_PR(misalign_PR)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] data;
      logic [4:0]  wreg;
      logic        dwb;
      logic        m2r;
      logic        err;
      logic        mis;
      logic        cd;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic push(input logic [31:0] alu, input logic [31:0] data,
                       input logic [4:0] wreg, input logic dwb,
                       input logic m2r, input logic err,
                       input logic mis, input logic cd);
      exp_t x;
      x.alu = alu; x.data = data; x.wreg = wreg; x.dwb = dwb;
      x.m2r = m2r; x.err = err; x.mis = mis; x.cd = cd;
      sb.push_back(x);
   endtask

   always @(negedge CLK) begin
      if (RESET && out_valid) begin
         if (sb.size() == 0) begin
            chk("sb_extra", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("pr_alu", aluResult_PR, e.alu);
            if (e.cd) chk("pr_data", data_read_PR, e.data);
            chk("pr_wreg", 32'(writeRegister_PR), 32'(e.wreg));
            chk("pr_dwb", 32'(do_writeback_PR), 32'(e.dwb));
            chk("pr_m2r", 32'(MemtoReg_PR), 32'(e.m2r));
            chk("pr_err", 32'(dm_err_PR), 32'(e.err));
`ifdef MISALIGN_TRAP_EN
            chk("pr_mis", 32'(misalign_PR), 32'(e.mis));
`endif
         end
      end
   end

   // Called at a negedge with the DUT idle; returns at the negedge after the accept edge
   task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] rb, input logic [4:0] wreg,
                        input logic dwb, input logic m2r,
                        input logic mr, input logic mw);
      ALU_control = op; aluResult = addr; readDataB = rb;
      writeRegister = wreg; do_writeback = dwb; MemtoReg = m2r;
      MemRead = mr; MemWrite = mw; in_valid = 1'b1;
      @(negedge CLK);
      in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   task automatic serve(input int waits, input logic [31:0] rdata,
                        output int lo, output logic we_c,
                        output logic [3:0] be_c, output logic [31:0] wd_c,
                        output logic [31:0] ad_c);
      lo = 0; we_c = 0; be_c = 0; wd_c = 0; ad_c = 0;
      for (int i = 0; i <= waits; i++) begin
         if (i == 0) begin
            we_c = dm_we; be_c = dm_be; wd_c = dm_wdata; ad_c = dm_addr;
         end
         if (!in_ready) lo++;
         if (i == waits) begin dm_ack = 1'b1; dm_rdata = rdata; end
         @(negedge CLK);
      end
      dm_ack = 1'b0; dm_rdata = '0;
   endtask

   int          lo, n;
   logic        we_c;
   logic [3:0]  be_c;
   logic [31:0] wd_c, ad_c;

   initial begin
      #12;
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_req", 32'(dm_req), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_be", 32'(dm_be), 32'd0);
      chk("rst_addr", dm_addr, 32'd0);
      chk("rst_alu_pr", aluResult_PR, 32'd0);
      chk("rst_err", 32'(dm_err_PR), 32'd0);
      @(negedge CLK); RESET = 1'b1;
      @(negedge CLK);

      push(32'h1234, 0, 5'd5, 1, 0, 0, 0, 0);
      issue(6'b100000, 32'h1234, 32'h0, 5'd5, 1, 0, 0, 0);
      chk("alu_req", 32'(dm_req), 32'd0);
      chk("alu_valid", 32'(out_valid), 32'd1);
      @(negedge CLK);
      chk("alu_valid_drop", 32'(out_valid), 32'd0);

      push(32'h101, 32'hFFFF_FFF2, 5'd3, 1, 1, 0, 0, 1);
      issue(6'b100001, 32'h101, 32'h0, 5'd3, 1, 1, 1, 0);
      chk("lb_req", 32'(dm_req), 32'd1);
      serve(3, 32'h11F2_3344, lo, we_c, be_c, wd_c, ad_c);
      chk("lb_ready_low", 32'(lo), 32'd4);
      chk("lb_be", 32'(be_c), 32'b0100);
      chk("lb_ready_back", 32'(in_ready), 32'd1);

      push(32'h101, 32'h0000_00F2, 5'd3, 1, 1, 0, 0, 1);
      issue(6'b101010, 32'h101, 32'h0, 5'd3, 1, 1, 1, 0);
      serve(3, 32'h11F2_3344, lo, we_c, be_c, wd_c, ad_c);

      push(32'h2, 32'hFFFF_8001, 5'd4, 1, 1, 0, 0, 1);
      issue(6'b101011, 32'h2, 32'h0, 5'd4, 1, 1, 1, 0);
      serve(1, 32'h1234_8001, lo, we_c, be_c, wd_c, ad_c);
      chk("lh_be", 32'(be_c), 32'b0011);
      push(32'h2, 32'h0000_8001, 5'd4, 1, 1, 0, 0, 1);
      issue(6'b101100, 32'h2, 32'h0, 5'd4, 1, 1, 1, 0);
      serve(0, 32'h1234_8001, lo, we_c, be_c, wd_c, ad_c);

      writeData_WB = 32'h5C; writeRegister_WB = 5'd7;
      do_writeback_WB = 1'b1;
      push(32'h102, 0, 5'd7, 0, 0, 0, 0, 0);
      issue(6'b101000, 32'h102, 32'hAA, 5'd7, 0, 0, 0, 1);
      serve(1, 32'h0, lo, we_c, be_c, wd_c, ad_c);
      chk("sb_we", 32'(we_c), 32'd1);
      chk("sb_be", 32'(be_c), 32'b0010);
      chk("sb_bypass_wdata", wd_c, 32'h5C5C_5C5C);
      chk("sb_addr", ad_c, 32'h102);

      writeRegister_WB = 5'd0;
      push(32'h102, 0, 5'd0, 0, 0, 0, 0, 0);
      issue(6'b101000, 32'h102, 32'hAA, 5'd0, 0, 0, 0, 1);
      serve(0, 32'h0, lo, we_c, be_c, wd_c, ad_c);
      chk("sb_r0_wdata", wd_c, 32'hAAAA_AAAA);
      do_writeback_WB = 1'b0;

      push(32'h106, 0, 5'd2, 0, 0, 0, 0, 0);
      issue(6'b101001, 32'h106, 32'h1234_ABCD, 5'd2, 0, 0, 0, 1);
      serve(0, 32'h0, lo, we_c, be_c, wd_c, ad_c);
      chk("sh_be", 32'(be_c), 32'b0011);
      chk("sh_wdata", wd_c, 32'hABCD_ABCD);

      push(32'h201, 32'h2233_44DD, 5'd8, 1, 1, 0, 0, 1);
      issue(6'b101101, 32'h201, 32'hAABB_CCDD, 5'd8, 1, 1, 1, 0);
      serve(0, 32'h1122_3344, lo, we_c, be_c, wd_c, ad_c);
      chk("lwl_zero_wait_lat", 32'(lo), 32'd1);
      push(32'h201, 32'hAABB_1122, 5'd8, 1, 1, 0, 0, 1);
      issue(6'b101110, 32'h201, 32'hAABB_CCDD, 5'd8, 1, 1, 1, 0);
      serve(0, 32'h1122_3344, lo, we_c, be_c, wd_c, ad_c);

      push(32'h300, 0, 5'd9, 0, 1, 1, 0, 0);
      issue(6'b100011, 32'h300, 32'h0, 5'd9, 1, 1, 1, 0);
      n = 0;
      while (dm_req && n < 20) begin n++; @(negedge CLK); end
      chk("to_req_cycles", 32'(n), 32'd5);
      @(negedge CLK);

      push(32'h310, 32'h0000_0055, 5'd9, 1, 1, 0, 0, 1);
      issue(6'b101010, 32'h313, 32'h0, 5'd9, 1, 1, 1, 0);
      sb[sb.size()-1].alu = 32'h313;
      serve(4, 32'hAABB_CC55, lo, we_c, be_c, wd_c, ad_c);

      issue(6'b100011, 32'h400, 32'h0, 5'd10, 1, 1, 1, 0);
      @(posedge CLK);
      #2 RESET = 1'b0;
      #1;
      chk("rst_mid_req", 32'(dm_req), 32'd0);
      chk("rst_mid_ready", 32'(in_ready), 32'd1);
      @(negedge CLK); RESET = 1'b1;
      @(negedge CLK);

`ifdef MISALIGN_TRAP_EN
      push(32'h102, 0, 5'd11, 0, 1, 0, 1, 0);
      issue(6'b100011, 32'h102, 32'h0, 5'd11, 1, 1, 1, 0);
      chk("mis_no_req", 32'(dm_req), 32'd0);
      @(negedge CLK);
      chk("mis_no_req2", 32'(dm_req), 32'd0);
`else
      push(32'h102, 32'hCAFE_F00D, 5'd11, 1, 1, 0, 0, 1);
      issue(6'b100011, 32'h102, 32'h0, 5'd11, 1, 1, 1, 0);
      chk("mis_req", 32'(dm_req), 32'd1);
      serve(0, 32'hCAFE_F00D, lo, we_c, be_c, wd_c, ad_c);
      chk("mis_be", 32'(be_c), 32'b1111);
      chk("mis_addr", ad_c, 32'h100);
`endif

      repeat (3) @(negedge CLK);
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
